bin_loader: RTL and testbench



---
 rtl/bin_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_bin_loader.sv | 494 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_loader.sv
// Bin loader: writes one bin (clause rows + var/level state vectors) into sat_engine,
// starts the engine, captures its result and streams the clause array back out.
module bin_loader #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_load_i,
    input  logic [WIDTH_LVL-1:0]                 bin_num_i,
    input  logic [WIDTH_LVL-1:0]                 load_lvl_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_in_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_in_i,
    input  logic                                 cl_in_valid_i,
    output logic                                 cl_in_ready_o,
    input  logic [NUM_VARS*2-1:0]                cl_in_data_i,
    output logic [NUM_CLAUSES-1:0]               wr_carray_o,
    output logic [NUM_VARS*2-1:0]                clause_o,
    output logic [NUM_VARS-1:0]                  wr_var_states_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    output logic [NUM_LVLS-1:0]                  wr_lvl_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    output logic                                 start_core_o,
    output logic [WIDTH_LVL-1:0]                 cur_bin_num_o,
    output logic [WIDTH_LVL-1:0]                 load_lvl_o,
    output logic [WIDTH_LVL-1:0]                 base_lvl_o,
    output logic                                 base_lvl_en_o,
    input  logic                                 done_core_i,
    input  logic                                 sat_i,
    input  logic                                 unsat_i,
    input  logic [WIDTH_LVL-1:0]                 bkt_lvl_i,
    output logic [NUM_CLAUSES-1:0]               rd_carray_o,
    input  logic [NUM_VARS*2-1:0]                clause_i,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic                                 cl_out_valid_o,
    input  logic                                 cl_out_ready_i,
    output logic [NUM_VARS*2-1:0]                cl_out_data_o,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_res_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_res_o,
    output logic                                 sat_o,
    output logic                                 unsat_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic                                 done_o,
    output logic                                 busy_o
);

    localparam int KW  = $clog2(NUM_CLAUSES) + 1;
    localparam int RW  = NUM_VARS * 2;
    localparam int VSW = WIDTH_VAR_STATES * NUM_VARS;
    localparam int LSW = WIDTH_LVL_STATES * NUM_LVLS;

    typedef enum logic [3:0] {
        IDLE, LD_CL, LD_VS, LD_LS, START, RUN, RD_CL, RD_WAIT, DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [KW-1:0]          r_k;
    logic [NUM_CLAUSES-1:0] w_k_onehot;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_last_row;

    logic [WIDTH_LVL-1:0]   r_bin;
    logic [WIDTH_LVL-1:0]   r_lvl;
    logic [VSW-1:0]         r_vs;
    logic [LSW-1:0]         r_ls;

    logic [NUM_CLAUSES-1:0] r_wr_carray;
    logic [RW-1:0]          r_clause;

    logic                   r_sat;
    logic                   r_unsat;
    logic [WIDTH_LVL-1:0]   r_bkt;
    logic [VSW-1:0]         r_vs_res;
    logic [LSW-1:0]         r_ls_res;

    logic                   r_rd_cap;
    logic                   r_out_valid;
    logic [RW-1:0]          r_out_data;

    assign w_in_fire  = (r_state == LD_CL) && cl_in_valid_i;
    assign w_out_fire = (r_state == RD_WAIT) && r_out_valid && cl_out_ready_i;
    assign w_last_row = (r_k == KW'(NUM_CLAUSES - 1));

    always_comb begin
        w_k_onehot = '0;
        for (int unsigned i = 0; i < NUM_CLAUSES; i++) begin
            if (r_k == KW'(i)) w_k_onehot[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start_load_i) w_state_nxt = LD_CL;
            LD_CL:   if (w_in_fire && w_last_row) w_state_nxt = LD_VS;
            LD_VS:   w_state_nxt = LD_LS;
            LD_LS:   w_state_nxt = START;
            START:   w_state_nxt = RUN;
            RUN:     if (done_core_i) w_state_nxt = RD_CL;
            RD_CL:   w_state_nxt = RD_WAIT;
            RD_WAIT: if (w_out_fire) w_state_nxt = w_last_row ? DONE : RD_CL;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cl_in_ready_o   = 1'b0;
        wr_var_states_o = '0;
        wr_lvl_states_o = '0;
        start_core_o    = 1'b0;
        rd_carray_o     = '0;
        base_lvl_en_o   = 1'b0;
        done_o          = 1'b0;
        busy_o          = (r_state != IDLE);
        case (r_state)
            LD_CL:   cl_in_ready_o = 1'b1;
            LD_VS:   begin wr_var_states_o = '1; base_lvl_en_o = 1'b1; end
            LD_LS:   begin wr_lvl_states_o = '1; base_lvl_en_o = 1'b1; end
            START:   begin start_core_o = 1'b1; base_lvl_en_o = 1'b1; end
            RUN:     base_lvl_en_o = 1'b1;
            RD_CL:   rd_carray_o = w_k_onehot;
            DONE:    done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin <= '0;
            r_lvl <= '0;
            r_vs  <= '0;
            r_ls  <= '0;
        end else if (r_state == IDLE && start_load_i) begin
            r_bin <= bin_num_i;
            r_lvl <= load_lvl_i;
            r_vs  <= vars_states_in_i;
            r_ls  <= lvl_states_in_i;
        end
    end

    // Row counter is shared by load and readback; it ends each phase at NUM_CLAUSES.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k         <= '0;
            r_wr_carray <= '0;
            r_clause    <= '0;
        end else begin
            r_wr_carray <= '0;
            case (r_state)
                IDLE:    if (start_load_i) r_k <= '0;
                LD_CL: begin
                    if (w_in_fire) begin
                        r_wr_carray <= w_k_onehot;
                        r_clause    <= cl_in_data_i;
                        r_k         <= r_k + KW'(1);
                    end
                end
                RUN:     if (done_core_i) r_k <= '0;
                RD_WAIT: if (w_out_fire) r_k <= r_k + KW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sat    <= 1'b0;
            r_unsat  <= 1'b0;
            r_bkt    <= '0;
            r_vs_res <= '0;
            r_ls_res <= '0;
        end else if (r_state == RUN && done_core_i) begin
            r_sat    <= sat_i;
            r_unsat  <= unsat_i;
            r_bkt    <= bkt_lvl_i;
            r_vs_res <= vars_states_i;
            r_ls_res <= lvl_states_i;
        end
    end

    // clause_i is valid in the cycle after the read strobe, so capture is delayed one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_cap    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_rd_cap <= (r_state == RD_CL);
            if (r_rd_cap) begin
                r_out_data  <= clause_i;
                r_out_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign wr_carray_o       = r_wr_carray;
    assign clause_o          = r_clause;
    assign vars_states_o     = r_vs;
    assign lvl_states_o      = r_ls;
    assign cur_bin_num_o     = r_bin;
    assign load_lvl_o        = r_lvl;
    assign base_lvl_o        = r_lvl;
    assign cl_out_valid_o    = r_out_valid;
    assign cl_out_data_o     = r_out_data;
    assign vars_states_res_o = r_vs_res;
    assign lvl_states_res_o  = r_ls_res;
    assign sat_o             = r_sat;
    assign unsat_o           = r_unsat;
    assign bkt_lvl_o         = r_bkt;

endmodule

// File: tb/tb_bin_loader.sv
// Self-checking bench for bin_loader: a stand-in engine memory plus a monitor that logs
// every strobe; each test compares the log against the rows/vectors it chose.
module tb_bin_loader;

    localparam int NC  = 8;
    localparam int NV  = 8;
    localparam int NL  = 8;
    localparam int WL  = 16;
    localparam int VSW = 19 * NV;
    localparam int LSW = 11 * NL;
    localparam int RW  = NV * 2;

    typedef logic [RW-1:0] row_t;

    logic           clk, rst;
    logic           start_load_i;
    logic [WL-1:0]  bin_num_i, load_lvl_i;
    logic [VSW-1:0] vars_states_in_i;
    logic [LSW-1:0] lvl_states_in_i;
    logic           cl_in_valid_i, cl_in_ready_o;
    row_t           cl_in_data_i;
    logic [NC-1:0]  wr_carray_o;
    row_t           clause_o;
    logic [NV-1:0]  wr_var_states_o;
    logic [VSW-1:0] vars_states_o;
    logic [NL-1:0]  wr_lvl_states_o;
    logic [LSW-1:0] lvl_states_o;
    logic           start_core_o;
    logic [WL-1:0]  cur_bin_num_o, load_lvl_o, base_lvl_o;
    logic           base_lvl_en_o;
    logic           done_core_i, sat_i, unsat_i;
    logic [WL-1:0]  bkt_lvl_i;
    logic [NC-1:0]  rd_carray_o;
    row_t           clause_i;
    logic [VSW-1:0] vars_states_i;
    logic [LSW-1:0] lvl_states_i;
    logic           cl_out_valid_o, cl_out_ready_i;
    row_t           cl_out_data_o;
    logic [VSW-1:0] vars_states_res_o;
    logic [LSW-1:0] lvl_states_res_o;
    logic           sat_o, unsat_o;
    logic [WL-1:0]  bkt_lvl_o;
    logic           done_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bin_loader #(
        .NUM_CLAUSES(NC), .NUM_VARS(NV), .NUM_LVLS(NL), .WIDTH_LVL(WL),
        .WIDTH_VAR_STATES(19), .WIDTH_LVL_STATES(11)
    ) dut (
        .clk(clk), .rst(rst), .start_load_i(start_load_i), .bin_num_i(bin_num_i),
        .load_lvl_i(load_lvl_i), .vars_states_in_i(vars_states_in_i),
        .lvl_states_in_i(lvl_states_in_i), .cl_in_valid_i(cl_in_valid_i),
        .cl_in_ready_o(cl_in_ready_o), .cl_in_data_i(cl_in_data_i),
        .wr_carray_o(wr_carray_o), .clause_o(clause_o), .wr_var_states_o(wr_var_states_o),
        .vars_states_o(vars_states_o), .wr_lvl_states_o(wr_lvl_states_o),
        .lvl_states_o(lvl_states_o), .start_core_o(start_core_o),
        .cur_bin_num_o(cur_bin_num_o), .load_lvl_o(load_lvl_o), .base_lvl_o(base_lvl_o),
        .base_lvl_en_o(base_lvl_en_o), .done_core_i(done_core_i), .sat_i(sat_i),
        .unsat_i(unsat_i), .bkt_lvl_i(bkt_lvl_i), .rd_carray_o(rd_carray_o),
        .clause_i(clause_i), .vars_states_i(vars_states_i), .lvl_states_i(lvl_states_i),
        .cl_out_valid_o(cl_out_valid_o), .cl_out_ready_i(cl_out_ready_i),
        .cl_out_data_o(cl_out_data_o), .vars_states_res_o(vars_states_res_o),
        .lvl_states_res_o(lvl_states_res_o), .sat_o(sat_o), .unsat_o(unsat_o),
        .bkt_lvl_o(bkt_lvl_o), .done_o(done_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int idx_of(input logic [NC-1:0] v);
        if (!$onehot(v)) return -1;
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [VSW-1:0] rnd_vs();
        logic [159:0] t;
        for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
        return t[VSW-1:0];
    endfunction

    function automatic logic [LSW-1:0] rnd_ls();
        logic [95:0] t;
        for (int i = 0; i < 3; i++) t[i*32 +: 32] = $urandom;
        return t[LSW-1:0];
    endfunction

    // Engine stand-in: clause array written by wr_carray_o, read back one cycle after rd_carray_o.
    row_t eng_mem [NC];
    always @(posedge clk) begin
        if (idx_of(wr_carray_o) >= 0) eng_mem[idx_of(wr_carray_o)] <= clause_o;
        if (idx_of(rd_carray_o) >= 0) clause_i <= eng_mem[idx_of(rd_carray_o)];
        else                          clause_i <= row_t'($urandom);
    end

    int             wr_idx[$], wr_cy[$], vs_cy[$], ls_cy[$], st_cy[$], rd_idx[$];
    row_t           wr_dat[$];
    int             done_cnt = 0;
    logic [NV-1:0]  vs_strobe;
    logic [VSW-1:0] vs_seen;
    logic [NL-1:0]  ls_strobe;
    logic [LSW-1:0] ls_seen;
    logic [WL-1:0]  st_base;
    logic           st_base_en;

    always @(negedge clk) begin
        if (wr_carray_o != '0) begin
            wr_idx.push_back(idx_of(wr_carray_o));
            wr_dat.push_back(clause_o);
            wr_cy.push_back(cyc);
        end
        if (wr_var_states_o != '0) begin
            vs_cy.push_back(cyc);
            vs_strobe <= wr_var_states_o;
            vs_seen   <= vars_states_o;
        end
        if (wr_lvl_states_o != '0) begin
            ls_cy.push_back(cyc);
            ls_strobe <= wr_lvl_states_o;
            ls_seen   <= lvl_states_o;
        end
        if (start_core_o) begin
            st_cy.push_back(cyc);
            st_base    <= base_lvl_o;
            st_base_en <= base_lvl_en_o;
        end
        if (rd_carray_o != '0) rd_idx.push_back(idx_of(rd_carray_o));
        if (done_o) done_cnt <= done_cnt + 1;
    end

    row_t           job_rows [NC];
    logic [WL-1:0]  job_bin, job_lvl;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_job(input logic [WL-1:0] bin, input logic [WL-1:0] lvl,
                             input logic [VSW-1:0] vs, input logic [LSW-1:0] ls, output int c0);
        bin_num_i = bin; load_lvl_i = lvl; vars_states_in_i = vs; lvl_states_in_i = ls;
        start_load_i = 1'b1;
        tick();
        start_load_i = 1'b0;
        bin_num_i = WL'($urandom); load_lvl_i = WL'($urandom);
        vars_states_in_i = rnd_vs(); lvl_states_in_i = rnd_ls();
        c0 = cyc;
    endtask

    // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps
    task automatic feed_rows(input row_t rows [NC], input int n, input int mode, output bit ok);
        bit acc;
        ok = 1'b1;
        for (int r = 0; r < n; r++) begin
            int gaps;
            gaps = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
            cl_in_valid_i = 1'b0;
            repeat (gaps) tick();
            cl_in_valid_i = 1'b1;
            cl_in_data_i  = rows[r];
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                @(negedge clk);
                acc = cl_in_ready_o;
                tick();
            end
            if (!acc) begin ok = 1'b0; break; end
        end
        cl_in_valid_i = 1'b0;
        cl_in_data_i  = row_t'($urandom);
    endtask

    task automatic wait_start(input int sb, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (st_cy.size() > sb) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic engine_done(input logic s, input logic u, input logic [WL-1:0] bkt,
                               input logic [VSW-1:0] vsr, input logic [LSW-1:0] lsr);
        repeat ($urandom_range(0, 3)) tick();
        sat_i = s; unsat_i = u; bkt_lvl_i = bkt; vars_states_i = vsr; lvl_states_i = lsr;
        done_core_i = 1'b1;
        tick();
        done_core_i = 1'b0;
        sat_i = ~s; unsat_i = ~u; bkt_lvl_i = ~bkt; vars_states_i = ~vsr; lvl_states_i = ~lsr;
    endtask

    task automatic drain(input int bp_row, input int bp_len, output row_t got [NC], output bit ok);
        bit v;
        ok = 1'b1;
        for (int r = 0; r < NC; r++) got[r] = '0;
        cl_out_ready_i = 1'b0;
        for (int r = 0; r < NC; r++) begin
            v = 1'b0;
            for (int t = 0; t < 40; t++) begin
                @(negedge clk);
                if (cl_out_valid_o) begin v = 1'b1; break; end
            end
            if (!v) begin ok = 1'b0; tick(); return; end
            got[r] = cl_out_data_o;
            if (r == bp_row) begin
                for (int b = 0; b < bp_len; b++) begin
                    @(negedge clk);
                    n_tests++;
                    if ({cl_out_valid_o, cl_out_data_o} !== {1'b1, got[r]}) begin
                        n_fail++;
                        $display("FAIL bp_hold row %0d: got v=%b d=%h exp v=1 d=%h", r, cl_out_valid_o, cl_out_data_o, got[r]);
                    end
                    n_tests++;
                    if (rd_carray_o !== '0) begin
                        n_fail++;
                        $display("FAIL bp_no_read row %0d: got rd=%h exp 00", r, rd_carray_o);
                    end
                end
            end else begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            cl_out_ready_i = 1'b1;
            @(posedge clk); #1;
            cl_out_ready_i = 1'b0;
        end
    endtask

    task automatic wait_done(input int db, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (done_cnt > db) begin ok = 1'b1; break; end
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({wr_carray_o, wr_var_states_o, wr_lvl_states_o, rd_carray_o} !== '0) begin
            n_fail++; $display("FAIL reset_strobes: got %h exp 0", {wr_carray_o, wr_var_states_o, wr_lvl_states_o, rd_carray_o});
        end
        n_tests++;
        if ({start_core_o, done_o, busy_o, cl_in_ready_o, cl_out_valid_o, sat_o, unsat_o, base_lvl_en_o} !== '0) begin
            n_fail++; $display("FAIL reset_flags: got %b exp 0", {start_core_o, done_o, busy_o, cl_in_ready_o, cl_out_valid_o, sat_o, unsat_o, base_lvl_en_o});
        end
        n_tests++;
        if ({cur_bin_num_o, load_lvl_o, base_lvl_o, bkt_lvl_o, clause_o, cl_out_data_o} !== '0) begin
            n_fail++; $display("FAIL reset_words: got %h exp 0", {cur_bin_num_o, load_lvl_o, base_lvl_o, bkt_lvl_o, clause_o, cl_out_data_o});
        end
        n_tests++;
        if ({vars_states_o, lvl_states_o, vars_states_res_o, lvl_states_res_o} !== '0) begin
            n_fail++; $display("FAIL reset_vectors: got nonzero exp 0");
        end
        rst = 1'b1;
        tick();
        done_core_i = 1'b1; sat_i = 1'b1;
        tick();
        done_core_i = 1'b0; sat_i = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({busy_o, sat_o, rd_carray_o} !== '0) begin
            n_fail++; $display("FAIL idle_done_ignored: got busy=%b sat=%b rd=%h exp 0", busy_o, sat_o, rd_carray_o);
        end
    endtask

    task automatic test_load();
        logic [VSW-1:0] vs;
        logic [LSW-1:0] ls;
        int wb, vb, lb, sb, c0;
        bit ok;
        job_rows = '{16'h0009, 16'h0024, 16'h00A0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        job_bin = 16'h0005; job_lvl = 16'h0001;
        vs = rnd_vs(); ls = rnd_ls();
        wb = wr_idx.size(); vb = vs_cy.size(); lb = ls_cy.size(); sb = st_cy.size();
        start_job(job_bin, job_lvl, vs, ls, c0);
        n_tests++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL load_busy: got %b exp 1", busy_o); end
        feed_rows(job_rows, NC, 0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL load_accept: got timeout exp 8 beats"); end
        wait_start(sb, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL load_start_seen: got timeout exp start_core_o"); end
        n_tests++;
        if (wr_idx.size() - wb != NC) begin n_fail++; $display("FAIL load_wr_count: got %0d exp %0d", wr_idx.size() - wb, NC); end
        for (int i = 0; i < NC && wb + i < wr_idx.size(); i++) begin
            n_tests++;
            if (wr_idx[wb+i] != i || wr_dat[wb+i] !== job_rows[i] || wr_cy[wb+i] != c0 + 1 + i) begin
                n_fail++;
                $display("FAIL load_wr[%0d]: got row %0d data %h cyc %0d exp row %0d data %h cyc %0d",
                         i, wr_idx[wb+i], wr_dat[wb+i], wr_cy[wb+i] - c0, i, job_rows[i], 1 + i);
            end
        end
        n_tests++;
        if (vs_cy.size() - vb != 1 || vs_strobe !== '1 || vs_seen !== vs || (vs_cy.size() > vb && vs_cy[vb] != c0 + NC)) begin
            n_fail++; $display("FAIL load_var_states: got count %0d strobe %h exp 1 pulse of FF at cyc %0d", vs_cy.size() - vb, vs_strobe, NC);
        end
        n_tests++;
        if (ls_cy.size() - lb != 1 || ls_strobe !== '1 || ls_seen !== ls || (ls_cy.size() > lb && ls_cy[lb] != c0 + NC + 1)) begin
            n_fail++; $display("FAIL load_lvl_states: got count %0d strobe %h exp 1 pulse of FF at cyc %0d", ls_cy.size() - lb, ls_strobe, NC + 1);
        end
        // start_core_o is sampled by the engine NUM_CLAUSES+3 edges after the start_load_i edge
        n_tests++;
        if (st_cy.size() - sb != 1 || (st_cy.size() > sb && st_cy[sb] != c0 + NC + 2)) begin
            n_fail++; $display("FAIL load_start_timing: got count %0d exp 1 pulse at cyc %0d", st_cy.size() - sb, NC + 2);
        end
        n_tests++;
        if ({st_base, st_base_en} !== {job_lvl, 1'b1}) begin
            n_fail++; $display("FAIL load_base_lvl: got %h/%b exp %h/1", st_base, st_base_en, job_lvl);
        end
        n_tests++;
        if ({cur_bin_num_o, load_lvl_o} !== {job_bin, job_lvl}) begin
            n_fail++; $display("FAIL load_latched: got %h/%h exp %h/%h", cur_bin_num_o, load_lvl_o, job_bin, job_lvl);
        end
    endtask

    task automatic test_start_ignored();
        int wb, vb, sb;
        wb = wr_idx.size(); vb = vs_cy.size(); sb = st_cy.size();
        bin_num_i = ~job_bin; load_lvl_i = ~job_lvl;
        start_load_i = 1'b1; cl_in_valid_i = 1'b1;
        tick();
        start_load_i = 1'b0;
        repeat (3) tick();
        cl_in_valid_i = 1'b0;
        n_tests++;
        if (wr_idx.size() != wb || vs_cy.size() != vb || st_cy.size() != sb) begin
            n_fail++; $display("FAIL busy_start_strobes: got %0d/%0d/%0d new strobes exp 0", wr_idx.size() - wb, vs_cy.size() - vb, st_cy.size() - sb);
        end
        n_tests++;
        if ({cur_bin_num_o, load_lvl_o, busy_o, cl_in_ready_o} !== {job_bin, job_lvl, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL busy_start_latch: got bin %h lvl %h busy %b rdy %b exp %h %h 1 0", cur_bin_num_o, load_lvl_o, busy_o, cl_in_ready_o, job_bin, job_lvl);
        end
    endtask

    task automatic test_result_readback();
        logic [VSW-1:0] vsr;
        logic [LSW-1:0] lsr;
        row_t got [NC];
        int rb, db;
        bit ok;
        vsr = rnd_vs(); lsr = rnd_ls();
        rb = rd_idx.size(); db = done_cnt;
        engine_done(1'b1, 1'b0, '0, vsr, lsr);
        drain(3, 5, got, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rb_stream: got timeout exp %0d rows", NC); end
        wait_done(db, ok);
        for (int i = 0; i < NC; i++) begin
            n_tests++;
            if (got[i] !== job_rows[i]) begin n_fail++; $display("FAIL rb_row[%0d]: got %h exp %h", i, got[i], job_rows[i]); end
        end
        n_tests++;
        if (rd_idx.size() - rb != NC) begin n_fail++; $display("FAIL rb_read_count: got %0d exp %0d", rd_idx.size() - rb, NC); end
        for (int i = 0; i < NC && rb + i < rd_idx.size(); i++) begin
            n_tests++;
            if (rd_idx[rb+i] != i) begin n_fail++; $display("FAIL rb_read_order[%0d]: got %0d exp %0d", i, rd_idx[rb+i], i); end
        end
        n_tests++;
        if (done_cnt - db != 1) begin n_fail++; $display("FAIL rb_done_pulses: got %0d exp 1", done_cnt - db); end
        n_tests++;
        if ({sat_o, unsat_o, bkt_lvl_o, busy_o} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
            n_fail++; $display("FAIL rb_result: got sat %b unsat %b bkt %h busy %b exp 1 0 0000 0", sat_o, unsat_o, bkt_lvl_o, busy_o);
        end
        n_tests++;
        if ({vars_states_res_o, lvl_states_res_o} !== {vsr, lsr}) begin
            n_fail++; $display("FAIL rb_state_capture: got %h exp %h", {vars_states_res_o, lvl_states_res_o}, {vsr, lsr});
        end
    endtask

    task automatic run_and_check(input string tag, input int mode);
        row_t rows [NC];
        row_t got [NC];
        logic [WL-1:0] bin, lvl, bkt;
        logic [VSW-1:0] vs, vsr;
        logic [LSW-1:0] ls, lsr;
        logic s;
        int wb, rb, db, sb, c0;
        bit ok1, ok2, ok3, ok4;
        for (int i = 0; i < NC; i++) rows[i] = row_t'($urandom);
        bin = WL'($urandom); lvl = WL'($urandom); bkt = WL'($urandom);
        vs = rnd_vs(); ls = rnd_ls(); vsr = rnd_vs(); lsr = rnd_ls();
        s = 1'($urandom_range(0, 1));
        wb = wr_idx.size(); rb = rd_idx.size(); db = done_cnt; sb = st_cy.size();
        start_job(bin, lvl, vs, ls, c0);
        feed_rows(rows, NC, mode, ok1);
        wait_start(sb, ok2);
        engine_done(s, ~s, bkt, vsr, lsr);
        drain(-1, 0, got, ok3);
        wait_done(db, ok4);
        n_tests++;
        if (!(ok1 && ok2 && ok3 && ok4)) begin
            n_fail++; $display("FAIL %s_progress: got load/start/drain/done %b%b%b%b exp 1111", tag, ok1, ok2, ok3, ok4);
        end
        n_tests++;
        if (wr_idx.size() - wb != NC) begin n_fail++; $display("FAIL %s_wr_count: got %0d exp %0d", tag, wr_idx.size() - wb, NC); end
        for (int i = 0; i < NC && wb + i < wr_idx.size(); i++) begin
            n_tests++;
            if (wr_idx[wb+i] != i || wr_dat[wb+i] !== rows[i]) begin
                n_fail++; $display("FAIL %s_wr[%0d]: got row %0d data %h exp row %0d data %h", tag, i, wr_idx[wb+i], wr_dat[wb+i], i, rows[i]);
            end
        end
        for (int i = 0; i < NC; i++) begin
            n_tests++;
            if (got[i] !== rows[i]) begin n_fail++; $display("FAIL %s_rb[%0d]: got %h exp %h", tag, i, got[i], rows[i]); end
        end
        n_tests++;
        if (rd_idx.size() - rb != NC || done_cnt - db != 1) begin
            n_fail++; $display("FAIL %s_rd_done: got reads %0d done %0d exp %0d 1", tag, rd_idx.size() - rb, done_cnt - db, NC);
        end
        n_tests++;
        if ({sat_o, unsat_o, bkt_lvl_o, vars_states_res_o, lvl_states_res_o} !== {s, ~s, bkt, vsr, lsr}) begin
            n_fail++; $display("FAIL %s_result: got sat %b unsat %b bkt %h exp %b %b %h", tag, sat_o, unsat_o, bkt_lvl_o, s, ~s, bkt);
        end
        n_tests++;
        if ({cur_bin_num_o, load_lvl_o, busy_o} !== {bin, lvl, 1'b0}) begin
            n_fail++; $display("FAIL %s_latched: got %h %h busy %b exp %h %h 0", tag, cur_bin_num_o, load_lvl_o, busy_o, bin, lvl);
        end
    endtask

    task automatic test_throttled();
        run_and_check("throttled", 1);
    endtask

    task automatic test_reset_mid();
        row_t rows [NC];
        int wb, wb2, c0;
        bit ok;
        for (int i = 0; i < NC; i++) rows[i] = row_t'($urandom);
        wb = wr_idx.size();
        start_job(WL'($urandom), WL'($urandom), rnd_vs(), rnd_ls(), c0);
        feed_rows(rows, 4, 0, ok);
        n_tests++;
        if (!ok || wr_idx.size() - wb != 3 || wr_carray_o !== 8'h08) begin
            n_fail++; $display("FAIL mid_partial_load: got %0d logged, wr=%h exp 3 logged, wr=08", wr_idx.size() - wb, wr_carray_o);
        end
        #1 rst = 1'b0;
        #1;
        n_tests++;
        if ({wr_carray_o, wr_var_states_o, wr_lvl_states_o, rd_carray_o, start_core_o, done_o} !== '0) begin
            n_fail++; $display("FAIL mid_reset_strobes: got %h exp 0", {wr_carray_o, wr_var_states_o, wr_lvl_states_o, rd_carray_o, start_core_o, done_o});
        end
        n_tests++;
        if ({busy_o, cl_in_ready_o, cur_bin_num_o, clause_o, vars_states_o} !== '0) begin
            n_fail++; $display("FAIL mid_reset_state: got busy %b rdy %b bin %h clause %h exp 0", busy_o, cl_in_ready_o, cur_bin_num_o, clause_o);
        end
        wb2 = wr_idx.size();
        tick(); tick();
        n_tests++;
        if (wr_idx.size() != wb2) begin n_fail++; $display("FAIL mid_reset_quiet: got %0d strobes exp 0", wr_idx.size() - wb2); end
        rst = 1'b1;
        tick();
        run_and_check("after_reset", 2);
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 3; j++) begin
            done_core_i = 1'b1;
            tick();
            done_core_i = 1'b0;
            n_tests++;
            if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rand_idle_done[%0d]: got busy %b exp 0", j, busy_o); end
            run_and_check("random", 2);
        end
    endtask

    initial begin
        rst = 1'b0; start_load_i = 1'b0; bin_num_i = '0; load_lvl_i = '0;
        vars_states_in_i = '0; lvl_states_in_i = '0; cl_in_valid_i = 1'b0; cl_in_data_i = '0;
        done_core_i = 1'b0; sat_i = 1'b0; unsat_i = 1'b0; bkt_lvl_i = '0;
        vars_states_i = '0; lvl_states_i = '0; cl_out_ready_i = 1'b0;
        test_reset();
        test_load();
        test_start_ignored();
        test_result_readback();
        test_throttled();
        test_reset_mid();
        test_random_jobs();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion exp summary before 500000 time units");
        $fatal(1, "watchdog");
    end

endmodule
